iob_eth_mii_tx: RTL and testbench



---
 rtl/iob_eth_mii_tx.sv | 174 +++++++++++++++++
 tb/tb_iob_eth_mii_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_mii_tx.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_mii_tx
//  Purpose  : MII transmit framer. Sends preamble, SFD, frame body taken from
//             the byte buffer over valid/ready, optional zero pad and CRC-32,
//             as 4-bit nibbles (low nibble first) on tx_data/tx_en.
//  Options  : IOB_ETH_TX_PAD_EN - pad bodies shorter than 60 bytes with zeros
//  Revision : 1.0 - initial release
// ============================================================================
module iob_eth_mii_tx #(
    parameter int PREAMBLE_LEN = 7,
    parameter int NBYTES_W     = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NBYTES_W-1:0] nbytes,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic [3:0]          tx_data,
    output logic                tx_en,
    output logic                busy,
    output logic                done,
    output logic                underflow
);

    localparam int CNT_W = ($clog2(2 * PREAMBLE_LEN) > 3) ? $clog2(2 * PREAMBLE_LEN) : 3;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_pre  = 3'd1;
    localparam logic [2:0] c_st_sfd  = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
`ifdef IOB_ETH_TX_PAD_EN
    localparam logic [2:0] c_st_pad  = 3'd4;
`endif
    localparam logic [2:0] c_st_crc  = 3'd5;

    localparam logic [31:0]      c_poly     = 32'hEDB88320;
    localparam logic [CNT_W-1:0] c_pre_last = CNT_W'(2 * PREAMBLE_LEN - 1);

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;     // preamble / CRC nibble index
    logic                r_half;    // 1 while the high nibble of a byte is shown
    logic [3:0]          r_hi;      // high nibble waiting to be shown
    logic [NBYTES_W-1:0] r_rem;     // body bytes still to be fetched
    logic [31:0]         r_crc;
`ifdef IOB_ETH_TX_PAD_EN
    logic [5:0]          r_pad;     // pad bytes still to be sent
`endif

    // Reflected CRC-32 advanced by one byte, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ c_poly) : (x >> 1);
        end
        return x;
    endfunction

    // A new body byte is requested while the high nibble of the previous one is on the wire
    assign byte_ready = ((r_state == c_st_sfd) || (r_state == c_st_data)) && r_half && (r_rem != '0);

    // Framing sequencer; every MII output is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_half    <= 1'b0;
            r_hi      <= 4'h0;
            r_rem     <= '0;
            r_crc     <= 32'hFFFFFFFF;
`ifdef IOB_ETH_TX_PAD_EN
            r_pad     <= '0;
`endif
            tx_data   <= 4'h0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            done      <= 1'b0;
            underflow <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_rem   <= nbytes;
                        r_crc   <= 32'hFFFFFFFF;
                        r_cnt   <= '0;
                        r_state <= c_st_pre;
                        tx_data <= 4'h5;
                        tx_en   <= 1'b1;
                        busy    <= 1'b1;
`ifdef IOB_ETH_TX_PAD_EN
                        r_pad   <= (nbytes < NBYTES_W'(60)) ? 6'(NBYTES_W'(60) - nbytes) : 6'd0;
`endif
                    end
                end
                c_st_pre: begin
                    tx_data <= 4'h5;
                    if (r_cnt == c_pre_last) begin
                        r_state <= c_st_sfd;
                        r_half  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef IOB_ETH_TX_PAD_EN
                c_st_sfd, c_st_data, c_st_pad: begin
`else
                c_st_sfd, c_st_data: begin
`endif
                    if (!r_half) begin
                        // SFD high nibble is D; body/pad bytes show their stored high nibble
                        tx_data <= (r_state == c_st_sfd) ? 4'hD : r_hi;
                        r_half  <= 1'b1;
                    end else if (r_rem != '0) begin
                        if (byte_valid) begin
                            tx_data <= byte_data[3:0];
                            r_hi    <= byte_data[7:4];
                            r_crc   <= crc_byte(r_crc, byte_data);
                            r_rem   <= r_rem - 1'b1;
                            r_state <= c_st_data;
                            r_half  <= 1'b0;
                        end else begin
                            // Source starved: drop the frame without a CRC
                            r_state   <= c_st_idle;
                            tx_data   <= 4'h0;
                            tx_en     <= 1'b0;
                            busy      <= 1'b0;
                            underflow <= 1'b1;
                        end
`ifdef IOB_ETH_TX_PAD_EN
                    end else if (r_pad != '0) begin
                        tx_data <= 4'h0;
                        r_hi    <= 4'h0;
                        r_crc   <= crc_byte(r_crc, 8'h00);
                        r_pad   <= r_pad - 1'b1;
                        r_state <= c_st_pad;
                        r_half  <= 1'b0;
`endif
                    end else begin
                        // Body complete: first FCS nibble is the low nibble of ~crc
                        tx_data <= ~r_crc[3:0];
                        r_crc   <= {4'h0, r_crc[31:4]};
                        r_cnt   <= '0;
                        r_state <= c_st_crc;
                    end
                end
                c_st_crc: begin
                    if (r_cnt == CNT_W'(7)) begin
                        r_state <= c_st_idle;
                        tx_data <= 4'h0;
                        tx_en   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        tx_data <= ~r_crc[3:0];
                        r_crc   <= {4'h0, r_crc[31:4]};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    tx_en   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_mii_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_eth_mii_tx
//  Purpose  : Self-checking bench for iob_eth_mii_tx. Expected nibble streams
//             come from a frame-level model (preamble, SFD, body, pad, FCS).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_eth_mii_tx;

    localparam int PREAMBLE_LEN = 7;
    localparam int NBYTES_W     = 11;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [NBYTES_W-1:0] nbytes;
    logic [7:0]          byte_data;
    logic                byte_valid;
    logic                byte_ready;
    logic [3:0]          tx_data;
    logic                tx_en;
    logic                busy;
    logic                done;
    logic                underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] src[$];
    logic [3:0] cap[$];
    logic [3:0] exp_q[$];

    iob_eth_mii_tx #(
        .PREAMBLE_LEN(PREAMBLE_LEN),
        .NBYTES_W    (NBYTES_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .nbytes    (nbytes),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .busy      (busy),
        .done      (done),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ethernet FCS computed bit-serially over a byte sequence (LSB of each byte first)
    function automatic logic [31:0] ref_crc(input logic [7:0] m[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (m[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ m[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Whole-frame nibble stream the wire should carry for body src[0..n-1]
    task automatic build_expected(input int n);
        logic [7:0]  body[$];
        logic [31:0] fcs;
        exp_q = {};
        body  = {};
        for (int i = 0; i < 2 * PREAMBLE_LEN + 1; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int i = 0; i < n; i++) body.push_back(src[i]);
`ifdef IOB_ETH_TX_PAD_EN
        while (body.size() < 60) body.push_back(8'h00);
`endif
        fcs = ref_crc(body);
        foreach (body[i]) begin
            exp_q.push_back(body[i][3:0]);
            exp_q.push_back(body[i][7:4]);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(fcs[4*i +: 4]);
    endtask

    task automatic fill_random(input int n);
        src = {};
        for (int i = 0; i < n; i++) src.push_back(8'($urandom));
    endtask

    task automatic idle(input int k);
        start      = 1'b0;
        byte_valid = 1'($urandom);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            chk("idle_tx_en", {31'h0, tx_en}, 0);
            chk("idle_flags", {29'h0, done, underflow, busy}, 0);
        end
    endtask

    // Called at posedge+1 of the cycle in which start is to be raised; returns
    // at posedge+1 of the done/underflow cycle so a caller may chain a start.
    task automatic run_frame(input int n, input int abort_at, input bit mid_start);
        int cyc, n_done, n_uf, n_rdy, busy_lo, acc, budget;
        bit fin;
        build_expected(n);
        if (abort_at >= 0) exp_q = exp_q[0 : 2 * (PREAMBLE_LEN + 1) + 2 * abort_at - 1];
        cap = {};
        acc = 0; n_done = 0; n_uf = 0; n_rdy = 0; busy_lo = 0; cyc = 0; fin = 1'b0;
        budget = exp_q.size() + 10;
        start  = 1'b1;
        nbytes = NBYTES_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_latency", {31'h0, tx_en}, 1);
        while (!fin && cyc < budget) begin
            if (tx_en) begin
                cap.push_back(tx_data);
                if (!busy) busy_lo++;
            end
            if (done)       begin n_done++; fin = 1'b1; end
            if (underflow)  begin n_uf++;   fin = 1'b1; end
            if (byte_ready) n_rdy++;
            if (mid_start && cyc == 5) begin
                start  = 1'b1;
                nbytes = NBYTES_W'($urandom_range(1, 100));
            end else begin
                start = 1'b0;
            end
            byte_data  = (acc < src.size()) ? src[acc] : 8'($urandom);
            byte_valid = (acc == abort_at) ? 1'b0 : (byte_ready ? 1'b1 : 1'($urandom));
            if (byte_ready && byte_valid) acc++;
            if (!fin) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        if (!fin) chk("frame_timeout", 0, 1);
        chk("tx_en_cycles", cap.size(), exp_q.size());
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
            chk("nibble", {28'h0, cap[i]}, {28'h0, exp_q[i]});
            if (cap[i] !== exp_q[i]) break;
        end
        chk("done_pulses", n_done, (abort_at >= 0) ? 0 : 1);
        chk("underflow_pulses", n_uf, (abort_at >= 0) ? 1 : 0);
        chk("busy_low_in_frame", busy_lo, 0);
        chk("ready_cycles", n_rdy, (abort_at >= 0) ? abort_at + 1 : n);
        chk("end_tx_en", {31'h0, tx_en}, 0);
        chk("end_busy", {31'h0, busy}, 0);
        if (abort_at < 0) chk("end_tx_data", {28'h0, tx_data}, 0);
    endtask

    initial begin
        logic [31:0] fcs;
        logic [7:0]  rx[$];
        int          k, bad, acc;

        rst = 1'b1; start = 1'b0; nbytes = '0; byte_data = 8'h00; byte_valid = 1'b0;

        // Reset while idle
        repeat (5) @(posedge clk);
        #1;
        chk("rst_tx_en", {31'h0, tx_en}, 0);
        chk("rst_tx_data", {28'h0, tx_data}, 0);
        chk("rst_flags", {28'h0, byte_ready, busy, done, underflow}, 0);
        rst = 1'b0;
        idle(2);

        // Known CRC: "123456789"
        src = {};
        for (int i = 0; i < 9; i++) src.push_back(8'h31 + 8'(i));
        run_frame(9, -1, 1'b0);
`ifndef IOB_ETH_TX_PAD_EN
        fcs = '0;
        for (int i = 0; i < 8; i++) fcs[4*i +: 4] = cap[cap.size() - 8 + i];
        chk("known_fcs", fcs, 32'hCBF43926);
        chk("known_en_cycles", cap.size(), 42);
`endif
        idle(3);

        // Full 60-byte frame decoded by a receiver model
        src = '{8'h01, 8'h60, 8'h6E, 8'h11, 8'h02, 8'h0F,
                8'h01, 8'h60, 8'h6E, 8'h11, 8'h02, 8'h0F, 8'h08, 8'h00};
        for (int i = 0; i < 46; i++) src.push_back(8'(i));
        run_frame(60, -1, 1'b0);
        chk("full_en_cycles", cap.size(), 144);
        k = 0;
        while (k < cap.size() && cap[k] == 4'h5) k++;
        chk("rx_preamble_nibbles", k, 2 * PREAMBLE_LEN + 1);
        if (k < cap.size()) chk("rx_sfd", {28'h0, cap[k]}, 32'hD);
        rx = {};
        for (int j = k + 1; j + 1 < cap.size(); j += 2) rx.push_back({cap[j+1], cap[j]});
        chk("rx_len", rx.size(), 64);
        bad = 0;
        for (int i = 0; i < 60 && i < rx.size(); i++) if (rx[i] !== src[i]) bad++;
        chk("rx_bad_bytes", bad, 0);
        chk("rx_residue", ref_crc(rx), 32'h2144DF1C);
        idle(2);

        // Underflow at byte 10, then a clean frame
        fill_random(20);
        run_frame(20, 10, 1'b0);
        idle(2);
        run_frame(20, -1, 1'b0);
        idle(2);

        // Ignored mid-frame start, then back-to-back start in the done cycle
        fill_random(12);
        run_frame(12, -1, 1'b1);
        fill_random(5);
        run_frame(5, -1, 1'b0);
        idle(4);

        // Reset in the middle of the body
        fill_random(20);
        acc = 0;
        start = 1'b1; nbytes = NBYTES_W'(20);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            byte_data  = src[acc];
            byte_valid = 1'b1;
            if (byte_ready) acc++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tx_en", {31'h0, tx_en}, 0);
        chk("midrst_flags", {28'h0, byte_ready, busy, done, underflow}, 0);
        chk("midrst_tx_data", {28'h0, tx_data}, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("midrst_hold", {29'h0, done, underflow, tx_en}, 0);
        end
        rst = 1'b0;
        fill_random(33);
        run_frame(33, -1, 1'b0);
        idle(2);

        // Empty body and short body (pad boundary)
        run_frame(0, -1, 1'b0);
        idle(1);
        fill_random(14);
        run_frame(14, -1, 1'b0);
`ifdef IOB_ETH_TX_PAD_EN
        chk("pad_en_cycles", cap.size(), 144);
`else
        chk("nopad_en_cycles", cap.size(), 2 * (PREAMBLE_LEN + 1 + 14 + 4));
`endif
        idle(2);

        // Random frames, some chained back-to-back, some with ignored starts
        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(0, 80);
            fill_random(n);
            run_frame(n, -1, 1'($urandom));
            if ($urandom_range(0, 1) == 0) idle(2);
        end
        idle(2);

        // Largest legal body length
        fill_random(2047);
        run_frame(2047, -1, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
